// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 16x oversampling; 8N1 by default.
// Define UART_RX_PARITY_EN to add one even-parity bit (8E1) and drive parity_err.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       framing_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic rx_s1, rx_s2, rx_prev;
  logic [1:0] fill;
  logic [TW-1:0] tcnt;
  logic [3:0] scnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic tick, fall, half, full, stop_hit, par_ok;
  assign tick = tcnt == TW'(DIV - 1);
  assign fall = rx_prev & ~rx_s2;
  assign half = tick && scnt == 4'd7;
  assign full = tick && scnt == 4'd15;
  assign stop_hit = state == STOP && full;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fall) state_n = START;
      START:   if (half) state_n = rx_s2 ? IDLE : DATA;
      DATA:    if (full && bcnt == 3'd7) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:  if (full) state_n = STOP;
`endif
      STOP:    if (full) state_n = rx_s2 ? IDLE : BREAK;
      BREAK:   if (tick && rx_s2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // fill marks when rx_s2 holds a real post-reset sample, so a line already low
  // at reset release cannot fake a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b0;
      fill        <= 2'b00;
      state       <= IDLE;
      tcnt        <= '0;
      scnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      fill        <= {fill[0], 1'b1};
      rx_prev     <= fill[1] & rx_s2;
      state       <= state_n;
      tcnt        <= (state == IDLE || tick) ? '0 : tcnt + TW'(1);
      scnt        <= (state == IDLE || (state == START && half) || full) ? '0 : tick ? scnt + 4'd1 : scnt;
      if (state == DATA && full) begin
        bcnt  <= bcnt + 3'd1;
        shreg <= {rx_s2, shreg[7:1]};
      end
      if (stop_hit && rx_s2 && par_ok) rx_data <= shreg;
      data_valid  <= stop_hit && rx_s2 && par_ok;
      framing_err <= stop_hit && !rx_s2;
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && full) par_bit <= rx_s2;
      parity_err <= stop_hit && rx_s2 && !par_ok;
    end
  end
`else
  assign par_ok = 1'b1;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked against a queue of expected
// frame outcomes (kind, byte, start time) derived from how each frame was sent.
module tb_uart_rx;
  localparam int BIT = 32;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 9;
  localparam bit PAR = 1'b0;
`endif
  localparam longint LAT_MIN = NB * BIT + BIT / 2 - 4;
  localparam longint LAT_MAX = NB * BIT + BIT / 2 + 8;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic data_valid, framing_err, parity_err, busy;
  typedef struct { int kind; logic [7:0] data; longint t0; } ev_t;
  ev_t exp_q[$];
  logic [7:0] model_data = 8'h00;
  longint cyc = 0;
  int vectors = 0, errors = 0, dv_n = 0, fe_n = 0, pe_n = 0;

  uart_rx #(.CLK_FREQ(3200000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .data_valid(data_valid),
    .framing_err(framing_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // kind: 0 data_valid, 1 framing_err, 2 parity_err
  always @(negedge clk) begin
    if (rst_n) begin
      logic [2:0] got;
      ev_t ev;
      longint lat;
      got = {parity_err, framing_err, data_valid};
      if (data_valid) dv_n++;
      if (framing_err) fe_n++;
      if (parity_err) pe_n++;
      if (got !== 3'b000) begin
        if (exp_q.size() == 0) check("unexpected pulse", got, 0);
        else begin
          ev = exp_q.pop_front();
          check("pulse kind", got, 64'd1 << ev.kind);
          lat = cyc - ev.t0;
          check("pulse latency in window", lat >= LAT_MIN && lat <= LAT_MAX, 1);
          if (ev.kind == 0) model_data = ev.data;
        end
      end else if (exp_q.size() != 0 && cyc - exp_q[0].t0 > LAT_MAX + 40) begin
        check("missing pulse", 0, 1);
        void'(exp_q.pop_front());
      end
      check("rx_data", rx_data, model_data);
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic bad_par, input int gap);
    ev_t ev;
    ev.kind = !stop ? 1 : bad_par ? 2 : 0;
    ev.data = d;
    ev.t0 = cyc;
    exp_q.push_back(ev);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    if (PAR) drive(^d ^ bad_par, BIT);
    drive(stop, BIT);
    if (gap > 0) drive(1'b1, gap);
  endtask

  initial begin
    logic [7:0] d, b55;
    logic st, bp;
    int gap, dv0, fe0;
    #12;
    check("reset rx_data", rx_data, 8'h00);
    check("reset busy", busy, 0);
    check("reset pulses", {parity_err, framing_err, data_valid}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2 * BIT);
    send(8'h31, 1'b1, 1'b0, BIT);
    check("0x31 rx_data", rx_data, 8'h31);
    check("0x31 dv count", dv_n, 1);
    check("0x31 busy after", busy, 0);
    send(8'h61, 1'b1, 1'b0, 0);
    check("b2b first rx_data", rx_data, 8'h61);
    send(8'h43, 1'b1, 1'b0, BIT);
    check("b2b second rx_data", rx_data, 8'h43);
    check("b2b dv count", dv_n, 3);
    drive(1'b0, 10);
    drive(1'b1, 2 * BIT);
    check("glitch busy", busy, 0);
    check("glitch no pulse", dv_n + fe_n + pe_n, 3);
    send(8'h63, 1'b0, 1'b0, 0);
    drive(1'b0, 1000);
    drive(1'b1, 2 * BIT);
    check("break fe count", fe_n, 1);
    check("break rx_data kept", rx_data, 8'h43);
    send(8'h30, 1'b1, 1'b0, BIT);
    check("after break rx_data", rx_data, 8'h30);
    b55 = 8'h55;
    dv0 = dv_n;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b55[i], BIT);
    drive(b55[4], 10);
    #2;
    rst_n = 1'b0;
    model_data = 8'h00;
    #1;
    check("mid-frame reset busy", busy, 0);
    check("mid-frame reset rx_data", rx_data, 8'h00);
    @(posedge clk);
    #1;
    drive(b55[4], BIT - 11);
    drive(b55[5], BIT);
    drive(b55[6], BIT);
    drive(b55[7], 10);
    rst_n = 1'b1;
    drive(b55[7], BIT - 10);
    drive(1'b1, 2 * BIT);
    check("reset discard no pulse", dv_n + fe_n + pe_n, dv0 + 1);
    send(8'h62, 1'b1, 1'b0, BIT);
    check("after reset rx_data", rx_data, 8'h62);
    if (PAR) begin
      send(8'h31, 1'b1, 1'b1, BIT);
      check("parity bad pe count", pe_n, 1);
      check("parity bad rx_data kept", rx_data, 8'h62);
      send(8'h31, 1'b1, 1'b0, BIT);
      check("parity good rx_data", rx_data, 8'h31);
    end
    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      st = $urandom_range(7) != 0;
      bp = PAR && $urandom_range(3) == 0;
      gap = st ? int'($urandom_range(40)) : 0;
      send(d, st, bp, gap);
      if (!st) begin
        drive(1'b0, 1 + int'($urandom_range(100)));
        drive(1'b1, 2 * BIT);
      end
    end
    fe0 = fe_n;
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("events drained", exp_q.size(), 0);
    check("final busy", busy, 0);
    check("final fe stable", fe_n, fe0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line; idles high.
REQ-006 The block SHALL have port rx_data, output, 8 bits: last correctly framed byte.
REQ-007 The block SHALL have port data_valid, output, 1 bit: single-cycle pulse; rx_data is new.
REQ-008 The block SHALL have port framing_err, output, 1 bit: single-cycle pulse; stop bit sampled low.
REQ-009 The block SHALL have port parity_err, output, 1 bit: single-cycle pulse; parity mismatch (see REQ-026).
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-011 The block SHALL pass rx through a 2-flop synchronizer before any use; both flops hold 1 in reset.
REQ-012 The block SHALL generate an oversample tick every OVS_DIV = CLK_FREQ/(BAUD_RATE*16) clocks (integer division, minimum 1); the tick counter SHALL be cleared on entry to START.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-014 In IDLE, a synchronized high-to-low transition SHALL move the FSM to START.
REQ-015 In START, the line SHALL be sampled at the 8th tick; if low, go to DATA; if high (glitch), return to IDLE with no output pulse.
REQ-016 In DATA, 8 bits SHALL be sampled, each 16 ticks after the previous sample, LSB first, into a shift register; a 3-bit bit counter SHALL wrap 7->0 on exit.
REQ-017 In STOP, the line SHALL be sampled 16 ticks after the last data or parity sample.
REQ-018 If the stop sample is high and there is no parity error, the block SHALL load rx_data from the shift register and pulse data_valid for exactly one clk, on the clk after the sample, then return to IDLE.
REQ-019 If the stop sample is low, the block SHALL pulse framing_err for one clk, leave rx_data unchanged, and go to BREAK.
REQ-020 BREAK SHALL remain until the synchronized rx is high for one tick, then go to IDLE, so that a held-low line produces exactly one framing_err.
REQ-021 rx_data SHALL hold its value between frames; data_valid, framing_err and parity_err SHALL never be high together.
REQ-022 Back-to-back frames SHALL be received with no idle gap beyond the stop bit; the next falling edge is accepted in IDLE immediately after the STOP exit.

Reset
REQ-023 When rst_n is asserted, the block SHALL reset immediately: rx_data=8'h00, data_valid=0, framing_err=0, parity_err=0, busy=0, FSM=IDLE, and all counters and the shift register cleared.
REQ-024 A reset asserted mid-frame SHALL discard the partial byte with no pulse; after release, the remainder of the frame SHALL be ignored until the line has been seen high in IDLE followed by a new falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL select the parity feature.
REQ-026 With UART_RX_PARITY_EN defined, one even-parity bit SHALL follow the data bits (state PARITY, 16 ticks after bit 7). On a mismatch with a high stop bit, the block SHALL pulse parity_err instead of data_valid and leave rx_data unchanged. A low stop bit SHALL give framing_err only.
REQ-027 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be tied to 0.

Verification (bench: CLK_FREQ=3200000, BAUD_RATE=100000, giving OVS_DIV=2 and 32 clk/bit)
REQ-028 Send frame 0x31 (8N1) -> rx_data=8'h31 with one data_valid pulse, about 304 clk after the start edge; busy low afterwards.
REQ-029 Send 0x61 then 0x43 back-to-back with no gap -> two data_valid pulses; rx_data=8'h61 then 8'h43.
REQ-030 Drive rx low for 10 clk, then high -> no pulse of any kind; FSM returns to IDLE.
REQ-031 Send 0x63 with the stop bit low, then hold rx low for 1000 clk -> exactly one framing_err; rx_data keeps its prior value; the next frame 0x30 is received correctly.
REQ-032 Assert rst_n low during bit 4 of 0x55, release it, then send 0x62 -> no pulse for 0x55; rx_data=8'h62.
REQ-033 With UART_RX_PARITY_EN defined, send 0x31 with parity bit 0 (wrong; correct is 1) -> parity_err pulse and no data_valid; then 0x31 with parity bit 1 -> data_valid with rx_data=8'h31.
